friscv_cache_wport_arbiter: RTL and testbench
=============================================

# friscv_cache_wport_arbiter

Arbiter and sequencer for a cache block RAM write port shared between the cache flush engine and the AXI read-completion (refill) path. It converts the core's FENCE.i level request into a single flush pulse to the flusher. The pulse is issued only after all in-flight AXI refills have drained, so no stale block lands after the flush. It sits between the cache fetcher, the flusher and the cache RAM write port, and holds off new AXI reads while a flush is pending.

## Interface
- CACHE_BLOCK_W, 128, data bits per cache block
- AXI_ADDR_W, 12, address width
- MAX_OSTDG, 4, max outstanding AXI reads (counter width OW = $clog2(MAX_OSTDG+1))

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- srst  in  1  synchronous reset, active-high
- fence_req  in  1  flush request level, held until fence_ack
- fence_ack  out  1  one-cycle pulse, flush complete
- busy  out  1  draining or flushing
- ar_hold  out  1  upstream must not issue AXI reads while high
- rd_issue  in  1  pulse per accepted AXI AR
- refill_valid  in  1  refill block valid
- refill_ready  out  1  refill accepted when valid & ready
- refill_addr  in  AXI_ADDR_W  refill block address
- refill_data  in  CACHE_BLOCK_W  refill block data
- flusher_ready  in  1  flusher init done
- flush_blocks  out  1  one-cycle flush pulse to flusher
- flush_ack  in  1  flusher completion pulse
- flushing  in  1  flusher active
- flusher_wren  in  1  flusher write enable
- flusher_waddr  in  AXI_ADDR_W  flusher write address
- flusher_wdata  in  CACHE_BLOCK_W  flusher write data
- cache_wren  out  1  RAM write enable
- cache_waddr  out  AXI_ADDR_W  RAM write address
- cache_wdata  out  CACHE_BLOCK_W  RAM write data

## Operation
- Outstanding counter `ostdg` (OW bits):
  - +1 on rd_issue.
  - −1 on a refill handshake.
  - Both in the same cycle: unchanged.
  - Never wraps. rd_issue at MAX_OSTDG or refill at 0 is an upstream protocol violation; the count saturates.
- FSM states: IDLE, DRAIN, FLUSH, WAIT_ACK, DONE.
  - IDLE: fence_req=1 → DRAIN.
  - DRAIN: ostdg==0 and no refill word held → FLUSH. Refills are still accepted and written in DRAIN.
  - FLUSH: assert flush_blocks for exactly one cycle → WAIT_ACK.
  - WAIT_ACK: flush_ack=1 → DONE.
  - DONE: fence_ack=1 for one cycle → IDLE. fence_req must have dropped before the next request is recognised; IDLE requires fence_req low after DONE.
- ar_hold=1 when any of:
  - state != IDLE
  - ostdg==MAX_OSTDG
  - flusher_ready==0
- busy=1 whenever state != IDLE.
- Write port mux:
  - flusher_wren | flushing | !flusher_ready → flusher source. refill_ready=0.
  - Otherwise → refill source.
  - The flusher always wins a simultaneous request.
- cache_wren/waddr/wdata are registered from the selected source (1-cycle latency). wdata/waddr are held when wren=0.
- fence_req asserted during post-reset init (flusher_ready=0): the request waits in DRAIN and starts after init completes.
- flush_ack seen outside WAIT_ACK is ignored.
- srst: same effect as aresetn, synchronous.

## Timing
- Reset values: fence_ack=0, busy=0, ar_hold=1, refill_ready=0, flush_blocks=0, cache_wren=0, cache_waddr=0, cache_wdata=0, ostdg=0, state=IDLE.
- Refill accepted at cycle N appears on the cache write port at N+1.
- fence_req rising at N with ostdg==0:
  - busy at N+1
  - flush_blocks at N+2
  - fence_ack one cycle after flush_ack
- Reset mid-flush: FSM returns to IDLE, counter clears, no fence_ack is issued. The flusher re-inits via its own reset.

## Configuration
- FRISCV_REFILL_SKID_EN:
  - Defined: a one-entry skid buffer is inserted on the refill path and refill_ready is driven from a flop (=skid empty). A refill accepted while the port is granted to the flusher is held and written on the first free cycle. DRAIN also waits for the skid to empty.
  - Undefined: refill_ready is combinational (= refill grant); no storage.

## Test plan
- Reset release:
  - Stimulus: flusher_ready=0 for 32 cycles.
  - Expect: ar_hold=1 and refill_ready=0 throughout, and flusher writes pass through with 1-cycle latency.
  - After flusher_ready=1: ar_hold=0.
- Single refill:
  - Stimulus: rd_issue, then refill addr 0x040, data 0xA5…A5.
  - Expect: cache_wren for one cycle at addr 0x040 with that data, and ostdg back to 0.
- Fence with 2 outstanding reads:
  - Stimulus: fence_req while ostdg==2.
  - Expect: ar_hold=1, both refills written, flush_blocks only after the second refill, and one fence_ack after flush_ack.
- Collision:
  - Stimulus: refill_valid while flusher_wren=1.
  - Expect: flusher write wins and refill_ready=0. The refill is written the cycle after flusher_wren drops (with SKID_EN: accepted, then written from the skid).
- Counter edges:
  - Stimulus 1: MAX_OSTDG=4 rd_issue pulses → ar_hold=1.
  - Stimulus 2: rd_issue and a refill handshake in the same cycle → ostdg unchanged.
- Abort: srst asserted in WAIT_ACK → state IDLE, no fence_ack, all outputs at reset values.

Source files
------------

// File: rtl/friscv_cache_wport_arbiter.sv
// -----------------------------------------------------------------------------
// friscv_cache_wport_arbiter
//
// Shares the cache block RAM write port between the flush engine and the AXI
// refill path. It also turns the core's FENCE.i level request into a single
// flush pulse to the flusher. That pulse is issued only once every in-flight
// AXI refill has landed, so no stale block can be written after the flush.
//
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   fence_req / fence_ack / busy   : FENCE.i handshake with the core
//   ar_hold                        : blocks new AXI reads upstream
//   rd_issue                       : one pulse per accepted AXI AR
//   refill_valid/ready/addr/data   : refill block stream from the fetcher
//   flusher_ready, flush_blocks, flush_ack, flushing,
//   flusher_wren/waddr/wdata       : flusher control and write request
//   cache_wren/waddr/wdata         : registered RAM write port
//
// Optional feature (macro FRISCV_REFILL_SKID_EN):
//   When defined, a one-entry skid buffer sits on the refill path and
//   refill_ready comes from a flop. A refill accepted while the flusher owns
//   the port is parked and written on the first free cycle.
// -----------------------------------------------------------------------------
module friscv_cache_wport_arbiter #(
   parameter int CACHE_BLOCK_W = 128,
   parameter int AXI_ADDR_W    = 12,
   parameter int MAX_OSTDG     = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic                     fence_req,
   output logic                     fence_ack,
   output logic                     busy,
   output logic                     ar_hold,
   input  logic                     rd_issue,
   input  logic                     refill_valid,
   output logic                     refill_ready,
   input  logic [AXI_ADDR_W-1:0]    refill_addr,
   input  logic [CACHE_BLOCK_W-1:0] refill_data,
   input  logic                     flusher_ready,
   output logic                     flush_blocks,
   input  logic                     flush_ack,
   input  logic                     flushing,
   input  logic                     flusher_wren,
   input  logic [AXI_ADDR_W-1:0]    flusher_waddr,
   input  logic [CACHE_BLOCK_W-1:0] flusher_wdata,
   output logic                     cache_wren,
   output logic [AXI_ADDR_W-1:0]    cache_waddr,
   output logic [CACHE_BLOCK_W-1:0] cache_wdata
);

   localparam int OW = $clog2(MAX_OSTDG + 1);
   localparam logic [OW-1:0] OSTDG_MAX = OW'(MAX_OSTDG);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DRAIN    = 3'd1;
   localparam logic [2:0] FLUSH    = 3'd2;
   localparam logic [2:0] WAIT_ACK = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   logic [2:0]               state;
   logic [OW-1:0]            ostdg;
   logic                     rearm;          // set after DONE until fence_req drops
   logic                     flusher_sel;
   logic                     refill_grant;
   logic                     refill_hs;
   logic                     refill_pending; // refill word parked in the skid
   logic                     wr_req;
   logic [AXI_ADDR_W-1:0]    wr_addr;
   logic [CACHE_BLOCK_W-1:0] wr_data;

   // The flusher owns the port while it writes, while it is active and while it
   // is still initialising after reset.
   assign flusher_sel  = flusher_wren | flushing | ~flusher_ready;
   assign refill_grant = ~flusher_sel;

`ifdef FRISCV_REFILL_SKID_EN
   logic                     skid_valid;
   logic [AXI_ADDR_W-1:0]    skid_addr;
   logic [CACHE_BLOCK_W-1:0] skid_data;
   logic                     ready_q;

   assign refill_ready   = ready_q;
   assign refill_hs      = refill_valid & ready_q;
   assign refill_pending = skid_valid;
   assign wr_req         = refill_grant & (skid_valid | refill_hs);
   assign wr_addr        = skid_valid ? skid_addr : refill_addr;
   assign wr_data        = skid_valid ? skid_data : refill_data;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         skid_valid <= 1'b0;
         skid_addr  <= '0;
         skid_data  <= '0;
         ready_q    <= 1'b0;
      end else if (srst) begin
         skid_valid <= 1'b0;
         skid_addr  <= '0;
         skid_data  <= '0;
         ready_q    <= 1'b0;
      end else if (refill_hs && !refill_grant) begin
         // Accepted while the flusher owns the port: park it.
         skid_valid <= 1'b1;
         skid_addr  <= refill_addr;
         skid_data  <= refill_data;
         ready_q    <= 1'b0;
      end else if (skid_valid && refill_grant) begin
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         ready_q    <= ~skid_valid;
      end
   end
`else
   assign refill_ready   = refill_grant;
   assign refill_hs      = refill_valid & refill_grant;
   assign refill_pending = 1'b0;
   assign wr_req         = refill_hs;
   assign wr_addr        = refill_addr;
   assign wr_data        = refill_data;
`endif

   // Outstanding read counter; saturates on upstream protocol violations.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ostdg <= '0;
      end else if (srst) begin
         ostdg <= '0;
      end else begin
         case ({rd_issue, refill_hs})
            2'b10:   if (ostdg != OSTDG_MAX) ostdg <= ostdg + 1'b1;
            2'b01:   if (ostdg != '0)        ostdg <= ostdg - 1'b1;
            default: ostdg <= ostdg;
         endcase
      end
   end

   // Fence sequencer.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
         rearm <= 1'b0;
      end else if (srst) begin
         state <= IDLE;
         rearm <= 1'b0;
      end else begin
         if (state == DONE)   rearm <= 1'b1;
         else if (!fence_req) rearm <= 1'b0;

         case (state)
            IDLE:     if (fence_req && !rearm) state <= DRAIN;
            // Also waits for flusher init, so a fence during post-reset init
            // is deferred rather than lost.
            DRAIN:    if (ostdg == '0 && !refill_pending && flusher_ready)
                         state <= FLUSH;
            FLUSH:    state <= WAIT_ACK;
            WAIT_ACK: if (flush_ack) state <= DONE;
            DONE:     state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Registered RAM write port; address and data hold when no write.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cache_wren  <= 1'b0;
         cache_waddr <= '0;
         cache_wdata <= '0;
      end else if (srst) begin
         cache_wren  <= 1'b0;
         cache_waddr <= '0;
         cache_wdata <= '0;
      end else if (flusher_sel) begin
         cache_wren <= flusher_wren;
         if (flusher_wren) begin
            cache_waddr <= flusher_waddr;
            cache_wdata <= flusher_wdata;
         end
      end else if (wr_req) begin
         cache_wren  <= 1'b1;
         cache_waddr <= wr_addr;
         cache_wdata <= wr_data;
      end else begin
         cache_wren  <= 1'b0;
      end
   end

   assign busy         = (state != IDLE);
   assign flush_blocks = (state == FLUSH);
   assign fence_ack    = (state == DONE);
   assign ar_hold      = (state != IDLE) | (ostdg == OSTDG_MAX) | ~flusher_ready;

endmodule

// File: tb/tb_friscv_cache_wport_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for friscv_cache_wport_arbiter (default build).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_friscv_cache_wport_arbiter;

   logic         aclk = 1'b0;
   logic         aresetn, srst;
   logic         fence_req, fence_ack, busy, ar_hold, rd_issue;
   logic         refill_valid, refill_ready;
   logic [11:0]  refill_addr;
   logic [127:0] refill_data;
   logic         flusher_ready, flush_blocks, flush_ack, flushing, flusher_wren;
   logic [11:0]  flusher_waddr;
   logic [127:0] flusher_wdata;
   logic         cache_wren;
   logic [11:0]  cache_waddr;
   logic [127:0] cache_wdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   friscv_cache_wport_arbiter #(
      .CACHE_BLOCK_W(128), .AXI_ADDR_W(12), .MAX_OSTDG(4)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .fence_req(fence_req), .fence_ack(fence_ack), .busy(busy),
      .ar_hold(ar_hold), .rd_issue(rd_issue),
      .refill_valid(refill_valid), .refill_ready(refill_ready),
      .refill_addr(refill_addr), .refill_data(refill_data),
      .flusher_ready(flusher_ready), .flush_blocks(flush_blocks),
      .flush_ack(flush_ack), .flushing(flushing),
      .flusher_wren(flusher_wren), .flusher_waddr(flusher_waddr),
      .flusher_wdata(flusher_wdata),
      .cache_wren(cache_wren), .cache_waddr(cache_waddr),
      .cache_wdata(cache_wdata)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_fence_ack"},    fence_ack,    1'b0);
      check({pfx, "_busy"},         busy,         1'b0);
      check({pfx, "_ar_hold"},      ar_hold,      1'b1);
      check({pfx, "_refill_ready"}, refill_ready, 1'b0);
      check({pfx, "_flush_blocks"}, flush_blocks, 1'b0);
      check({pfx, "_cache_wren"},   cache_wren,   1'b0);
      check({pfx, "_cache_waddr"},  cache_waddr,  12'h000);
      check({pfx, "_cache_wdata"},  cache_wdata,  128'h0);
   endtask

   task automatic refill(input logic [11:0] a, input logic [127:0] d);
      refill_valid = 1'b1;
      refill_addr  = a;
      refill_data  = d;
      step();
      refill_valid = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0; srst = 1'b0;
      fence_req = 1'b0; rd_issue = 1'b0;
      refill_valid = 1'b0; refill_addr = '0; refill_data = '0;
      flusher_ready = 1'b0; flush_ack = 1'b0; flushing = 1'b0;
      flusher_wren = 1'b0; flusher_waddr = '0; flusher_wdata = '0;

      repeat (3) step();
      check_reset_values("rst");
      aresetn = 1'b1;

      // Flusher init: port owned by flusher, writes pass with 1-cycle latency.
      for (int i = 0; i < 32; i++) begin
         flusher_wren  = i[0];
         flusher_waddr = 12'(i);
         flusher_wdata = 128'(i * 3);
         step();
         check("init_ar_hold", ar_hold, 1'b1);
         check("init_refill_ready", refill_ready, 1'b0);
         check("init_wren", cache_wren, i[0]);
         if (i[0]) begin
            check("init_waddr", cache_waddr, 12'(i));
            check("init_wdata", cache_wdata, 128'(i * 3));
         end else if (i > 0) begin
            check("init_waddr_hold", cache_waddr, 12'(i - 1));
         end
      end
      flusher_wren = 1'b0;
      flusher_ready = 1'b1;
      #1;
      check("ready_ar_hold", ar_hold, 1'b0);
      check("ready_refill_ready", refill_ready, 1'b1);
      step();

      // Single refill.
      rd_issue = 1'b1;
      step();
      rd_issue = 1'b0;
      refill(12'h040, {16{8'hA5}});
      check("single_wren", cache_wren, 1'b1);
      check("single_waddr", cache_waddr, 12'h040);
      check("single_wdata", cache_wdata, {16{8'hA5}});
      step();
      check("single_wren_off", cache_wren, 1'b0);
      check("single_waddr_hold", cache_waddr, 12'h040);

      // Fence with nothing outstanding: busy at N+1, flush pulse at N+2.
      fence_req = 1'b1;
      step();
      check("f0_busy", busy, 1'b1);
      check("f0_ar_hold", ar_hold, 1'b1);
      check("f0_flush_early", flush_blocks, 1'b0);
      step();
      check("f0_flush", flush_blocks, 1'b1);
      step();
      check("f0_flush_once", flush_blocks, 1'b0);
      check("f0_fence_ack_early", fence_ack, 1'b0);
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
      check("f0_fence_ack", fence_ack, 1'b1);
      step();
      check("f0_fence_ack_once", fence_ack, 1'b0);
      check("f0_idle", busy, 1'b0);
      step();
      check("f0_no_retrigger", busy, 1'b0);
      fence_req = 1'b0;
      step();

      // Fence with two reads outstanding.
      rd_issue = 1'b1;
      step();
      step();
      rd_issue = 1'b0;
      fence_req = 1'b1;
      step();
      check("f2_busy", busy, 1'b1);
      check("f2_ar_hold", ar_hold, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("f2_drain_wait", flush_blocks, 1'b0);
      end
      refill(12'h100, 128'h1);
      check("f2_r1_waddr", cache_waddr, 12'h100);
      check("f2_r1_flush", flush_blocks, 1'b0);
      refill(12'h140, 128'h2);
      check("f2_r2_wren", cache_wren, 1'b1);
      check("f2_r2_waddr", cache_waddr, 12'h140);
      check("f2_r2_wdata", cache_wdata, 128'h2);
      check("f2_r2_flush", flush_blocks, 1'b0);
      step();
      check("f2_flush", flush_blocks, 1'b1);
      step();
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
      check("f2_fence_ack", fence_ack, 1'b1);
      fence_req = 1'b0;
      step();
      check("f2_fence_ack_once", fence_ack, 1'b0);
      check("f2_ar_release", ar_hold, 1'b0);

      // Collision: flusher wins, refill follows the cycle after.
      flusher_wren = 1'b1; flusher_waddr = 12'h200; flusher_wdata = 128'h7;
      refill_valid = 1'b1; refill_addr = 12'h240; refill_data = 128'h8;
      #1;
      check("col_refill_ready", refill_ready, 1'b0);
      step();
      check("col_flusher_waddr", cache_waddr, 12'h200);
      check("col_flusher_wdata", cache_wdata, 128'h7);
      flusher_wren = 1'b0;
      #1;
      check("col_refill_ready_back", refill_ready, 1'b1);
      step();
      refill_valid = 1'b0;
      check("col_refill_wren", cache_wren, 1'b1);
      check("col_refill_waddr", cache_waddr, 12'h240);
      check("col_refill_wdata", cache_wdata, 128'h8);

      // Counter edges (the unmatched refill above left the count at 0).
      rd_issue = 1'b1;
      repeat (3) step();
      check("cnt3_ar_hold", ar_hold, 1'b0);
      refill_valid = 1'b1; refill_addr = 12'h300; refill_data = 128'h9;
      step();
      refill_valid = 1'b0;
      check("cnt_both_ar_hold", ar_hold, 1'b0);
      step();
      check("cnt4_ar_hold", ar_hold, 1'b1);
      step();
      rd_issue = 1'b0;
      check("cnt_sat_ar_hold", ar_hold, 1'b1);
      for (int i = 0; i < 4; i++) refill(12'h310 + 12'(i), 128'(i));
      check("cnt_drained_ar_hold", ar_hold, 1'b0);

      // Abort: srst in WAIT_ACK (count must be 0 for the N+2 flush pulse).
      fence_req = 1'b1;
      step();
      step();
      check("ab_flush", flush_blocks, 1'b1);
      step();
      srst = 1'b1;
      flusher_ready = 1'b0;
      step();
      srst = 1'b0;
      fence_req = 1'b0;
      check_reset_values("ab");
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
      check("ab_stray_ack", fence_ack, 1'b0);
      check("ab_stray_busy", busy, 1'b0);
      step();
      check("ab_no_ack", fence_ack, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
